// File: rtl/cpu_pkg.sv
/*------------------------------------------------------------------------------
 * Module      : cpu_pkg
 * Description : Shared types and constants for the memory-port arbiter.
 * Revision    : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  // Access widths, RISC-V funct3 encoding
  localparam logic [2:0] MEM_WID_B  = 3'b000;
  localparam logic [2:0] MEM_WID_H  = 3'b001;
  localparam logic [2:0] MEM_WID_W  = 3'b010;
  localparam logic [2:0] MEM_WID_D  = 3'b011;
  localparam logic [2:0] MEM_WID_BU = 3'b100;
  localparam logic [2:0] MEM_WID_HU = 3'b101;
  localparam logic [2:0] MEM_WID_WU = 3'b110;

endpackage

`default_nettype wire

// File: rtl/arb_timeout_ctr.sv
/*------------------------------------------------------------------------------
 * Module      : arb_timeout_ctr
 * Description : Busy-cycle counter; flags the TIMEOUT_CYC-th enabled cycle.
 * Revision    : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module arb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = &{1'b0, clk_i, rst_i, load_i, en_i};
      assign expire_o = 1'b0;
    end else begin : g_enabled
      localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
          r_cnt <= '0;
        end else if (en_i) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // First enabled cycle sees 0, so the last allowed cycle sees TIMEOUT_CYC-1
      assign expire_o = en_i && (r_cnt == CW'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
/*------------------------------------------------------------------------------
 * Module      : mem_port_arbiter
 * Description : Serialises IF and MEM-stage accesses onto one single-port RAM.
 * Revision    : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  input  logic                  flush_i,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [2:0]            d_wid_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_wid_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  bus_err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            r_state, w_state_nxt;
  logic [SW-1:0]         r_starve_cnt;
  logic                  r_drop;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_wid;
  logic                  r_i_rvalid, r_d_rvalid, r_bus_err;
  logic [DATA_WIDTH-1:0] r_i_rdata, r_d_rdata;

  logic w_busy, w_ready, w_expire, w_done, w_drop, w_i_done, w_d_done;
  logic w_i_gnt, w_d_gnt, w_if_live, w_if_pri;

  assign w_busy    = (r_state != IDLE);
  assign w_ready   = w_busy && mem_ready_i;
  assign w_done    = w_ready || w_expire;
  assign w_drop    = r_drop || flush_i;
  assign w_i_done  = (r_state == BUSY_I) && w_done;
  assign w_d_done  = (r_state == BUSY_D) && w_done;
  // A flushed fetch is treated as absent so the data side is not blocked by it
  assign w_if_live = i_req_i && !flush_i;
  assign w_if_pri  = w_if_live && (r_starve_cnt == SW'(STARVE_LIMIT));

  arb_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (w_i_gnt || w_d_gnt),
    .en_i     (w_busy),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_d_gnt)      w_state_nxt = BUSY_D;
        else if (w_i_gnt) w_state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_i_gnt   = 1'b0;
    w_d_gnt   = 1'b0;
    mem_req_o = w_busy;
    if ((r_state == IDLE) && !rst_i) begin
      w_d_gnt = d_req_i && !w_if_pri;
      w_i_gnt = w_if_live && !w_d_gnt;
    end
  end

  assign i_gnt_o = w_i_gnt;
  assign d_gnt_o = w_d_gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (w_i_gnt || ((r_state == IDLE) && !i_req_i)) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && i_req_i && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wid   <= 3'b000;
    end else if (w_d_gnt) begin
      r_we    <= d_we_i;
      r_addr  <= d_addr_i;
      r_wdata <= d_wdata_i;
      r_wid   <= d_wid_i;
    end else if (w_i_gnt) begin
      r_we    <= 1'b0;
      r_addr  <= i_addr_i;
      r_wdata <= '0;
      r_wid   <= MEM_WID_D;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_done)                        r_drop <= 1'b0;
    else if ((r_state == BUSY_I) && flush_i)    r_drop <= 1'b1;
  end

  // Timed-out transactions return zero data; ready in the same cycle wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_i_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_i_rvalid <= w_i_done && !w_drop;
      r_i_rdata  <= (w_i_done && !w_drop && w_ready) ? mem_rdata_i : '0;
      r_d_rvalid <= w_d_done;
      r_d_rdata  <= (w_d_done && w_ready && !r_we) ? mem_rdata_i : '0;
      r_bus_err  <= w_expire && !w_ready;
    end
  end

  assign i_rvalid_o  = r_i_rvalid;
  assign i_rdata_o   = r_i_rdata;
  assign d_rvalid_o  = r_d_rvalid;
  assign d_rdata_o   = r_d_rdata;
  assign bus_err_o   = r_bus_err;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wid_o   = r_wid;

endmodule

`default_nettype wire
